fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage that sits directly downstream of the program counter register. It takes the current PC and issues a word read to the instruction cache. It waits out cache misses and buffers a returned instruction while decode is stalled. It drives the IF/ID pipeline register and also produces the stall signal fed back to the PC, so the PC advances only when an instruction has actually been handed to decode.

## Interface
- XLEN, 32: address/data width.
- NOP, 32'h00000013: bubble instruction inserted on flush/reset.
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- pc_i  in  XLEN  current PC (PC register output).
- id_stall_i  in  1  hazard unit: hold IF/ID (load-use etc.).
- flush_i  in  1  redirect from branch/jump resolution. Level signal, held by source until stall_o is low.
- ic_req_o  out  1  instruction cache read request.
- ic_addr_o  out  XLEN  cache read address.
- ic_stall_i  in  1  cache busy. Data valid in any cycle with ic_req_o=1 and ic_stall_i=0.
- ic_rdata_i  in  XLEN  cache read data.
- stall_o  out  1  to PC stall input; high = PC must hold.
- ifid_pc_o  out  XLEN  IF/ID PC.
- ifid_instr_o  out  XLEN  IF/ID instruction.
- ifid_valid_o  out  1  IF/ID holds a real instruction.

## Operation
- FSM states:
  - S_REQ: new request, ic_addr_o = pc_i.
  - S_WAIT: miss outstanding, ic_addr_o = latched addr_q.
  - S_BUF: instruction held in buf_q, ic_req_o = 0.
- ic_req_o = 1 in S_REQ and S_WAIT.
- done = ic_req_o & ~ic_stall_i (combinational).
- S_REQ:
  - ic_stall_i=1: latch addr_q = pc_i, go to S_WAIT.
  - done & id_stall_i & ~flush_i: buf_q = ic_rdata_i, bpc_q = pc_i, go to S_BUF.
  - Otherwise stay.
- S_WAIT:
  - done & ~flush_i & id_stall_i: capture into buffer, go to S_BUF.
  - done otherwise: go to S_REQ.
  - Cache access is never cancelled.
- S_BUF:
  - ~id_stall_i or flush_i: go to S_REQ.
- IF/ID update priority: reset > flush_i > id_stall_i (hold) > load.
  - Load source is buf_q/bpc_q in S_BUF; otherwise ic_rdata_i plus pc_i (S_REQ) or addr_q (S_WAIT), only when done.
  - Flush loads NOP, valid=0, pc unchanged.
  - Not done and no flush: load NOP, valid=0 (bubble).
- stall_o is low exactly when the PC may take its next value:
  - flush_i & (state≠S_WAIT | done), or
  - ~id_stall_i & (done | state==S_BUF).
  - High otherwise.
- On flush with done: the returned wrong-path data is discarded.

## Timing
- Reset (rst_n=0 at edge):
  - state=S_REQ.
  - ifid_instr_o=NOP, ifid_valid_o=0, ifid_pc_o=0.
  - buf_q=0, bpc_q=0, addr_q=0.
  - Combinational outputs follow from the state.
- Cache hit, no stall: instruction at PC p appears on IF/ID one edge after the request cycle. stall_o=0 in that cycle, so throughput is 1 instruction/cycle.
- Miss of N stall cycles: stall_o high for N cycles, with N bubbles in IF/ID.
- S_BUF exit: buffered instruction enters IF/ID on the edge where id_stall_i is low. The request for the next PC issues the cycle after.
- Flush while in S_WAIT: stall_o stays high until the cache completes, then goes low for one cycle. The flush takes effect on that edge.
- Reset mid-miss: FSM returns to S_REQ. Any late cache response is ignored; the cache is reset in the same cycle.

## Structure
- Shared package:
  - FSM state enum (S_REQ, S_WAIT, S_BUF).
  - NOP constant.
  - XLEN default.
- One natural sub-module, ifid_reg: the IF/ID register with flush/hold/load priority.

## Test plan
- Hits, no stalls, pc 0,4,8: IF/ID shows (0,i0),(4,i1),(8,i2) on consecutive edges; stall_o=0 throughout.
- Miss at pc 0x40 with ic_stall_i high 3 cycles: stall_o=1 for 3 cycles and 3 NOP bubbles (valid=0), then (0x40,instr) with valid=1.
- Hit at 0x10 while id_stall_i=1 for 2 cycles: enters S_BUF and IF/ID holds its old value. On release, (0x10,instr) loads and stall_o drops that cycle.
- flush_i during a 2-cycle miss: returned data is dropped; IF/ID becomes NOP/valid=0 on completion; stall_o low exactly one cycle.
- flush_i while in S_BUF with id_stall_i=1: buffer is discarded, IF/ID gets NOP, state goes to S_REQ, stall_o=0.
- rst_n low mid-miss: next edge gives ifid_instr_o=NOP, ifid_valid_o=0, ifid_pc_o=0, and a fresh request from pc_i.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM states and the bubble instruction.
package fetch_stage_pkg;

  localparam int unsigned XLEN_DEF = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_BUF  = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_stage_ifid_reg.sv
// IF/ID pipeline register: reset > flush > hold > load, bubble (NOP, invalid) when nothing to load.
module ifid_reg #(
  parameter int unsigned     XLEN = 32,
  parameter logic [XLEN-1:0] NOP  = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            hold,
  input  logic            load,
  input  logic [XLEN-1:0] ld_pc,
  input  logic [XLEN-1:0] ld_instr,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] instr,
  output logic            valid
);

  // Bubbles and flushes keep the previous PC; only a real load updates it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc    <= '0;
      instr <= NOP;
      valid <= 1'b0;
    end else if (flush) begin
      instr <= NOP;
      valid <= 1'b0;
    end else if (!hold) begin
      if (load) begin
        pc    <= ld_pc;
        instr <= ld_instr;
        valid <= 1'b1;
      end else begin
        instr <= NOP;
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: issues I-cache reads from the PC, rides out misses, buffers an
// instruction while decode stalls, and tells the PC when it may advance.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int unsigned     XLEN = XLEN_DEF,
  parameter logic [XLEN-1:0] NOP  = XLEN'(NOP_INSTR)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] pc_i,
  input  logic            id_stall_i,
  input  logic            flush_i,
  output logic            ic_req_o,
  output logic [XLEN-1:0] ic_addr_o,
  input  logic            ic_stall_i,
  input  logic [XLEN-1:0] ic_rdata_i,
  output logic            stall_o,
  output logic [XLEN-1:0] ifid_pc_o,
  output logic [XLEN-1:0] ifid_instr_o,
  output logic            ifid_valid_o
);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] addr_q, buf_q, bpc_q;
  logic            done, addr_en, buf_en, ld_en;
  logic [XLEN-1:0] ld_pc, ld_instr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_REQ;
      addr_q  <= '0;
      buf_q   <= '0;
      bpc_q   <= '0;
    end else begin
      state_q <= state_d;
      if (addr_en) addr_q <= pc_i;
      if (buf_en) begin
        buf_q <= ic_rdata_i;
        bpc_q <= ic_addr_o;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_en   = 1'b0;
    buf_en    = 1'b0;
    ic_req_o  = (state_q != S_BUF);
    ic_addr_o = (state_q == S_WAIT) ? addr_q : pc_i;
    done      = ic_req_o & ~ic_stall_i;
    ld_en     = done | (state_q == S_BUF);
    ld_pc     = (state_q == S_BUF) ? bpc_q : ic_addr_o;
    ld_instr  = (state_q == S_BUF) ? buf_q : ic_rdata_i;
    stall_o   = ~((flush_i & ((state_q != S_WAIT) | done)) |
                  (~id_stall_i & ld_en));

    unique case (state_q)
      S_REQ: begin
        if (ic_stall_i) begin
          addr_en = 1'b1;
          state_d = S_WAIT;
        end else if (id_stall_i && !flush_i) begin
          buf_en  = 1'b1;
          state_d = S_BUF;
        end
      end
      S_WAIT: begin
        // The outstanding access always runs to completion, even under flush.
        if (done) begin
          if (id_stall_i && !flush_i) begin
            buf_en  = 1'b1;
            state_d = S_BUF;
          end else begin
            state_d = S_REQ;
          end
        end
      end
      S_BUF: begin
        if (!id_stall_i || flush_i) state_d = S_REQ;
      end
      default: state_d = S_REQ;
    endcase
  end

  ifid_reg #(
    .XLEN (XLEN),
    .NOP  (NOP)
  ) u_ifid (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush_i),
    .hold     (id_stall_i),
    .load     (ld_en),
    .ld_pc    (ld_pc),
    .ld_instr (ld_instr),
    .pc       (ifid_pc_o),
    .instr    (ifid_instr_o),
    .valid    (ifid_valid_o)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: hits, miss, decode stall, flushes and reset mid-miss.
module tb_fetch_stage;

  localparam logic [31:0] NOPI = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc_i;
  logic        id_stall_i;
  logic        flush_i;
  logic        ic_req_o;
  logic [31:0] ic_addr_o;
  logic        ic_stall_i;
  logic [31:0] ic_rdata_i;
  logic        stall_o;
  logic [31:0] ifid_pc_o;
  logic [31:0] ifid_instr_o;
  logic        ifid_valid_o;

  int unsigned total = 0;
  int unsigned bad   = 0;

  always #5 clk = ~clk;

  fetch_stage #(
    .XLEN (32),
    .NOP  (32'h0000_0013)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pc_i         (pc_i),
    .id_stall_i   (id_stall_i),
    .flush_i      (flush_i),
    .ic_req_o     (ic_req_o),
    .ic_addr_o    (ic_addr_o),
    .ic_stall_i   (ic_stall_i),
    .ic_rdata_i   (ic_rdata_i),
    .stall_o      (stall_o),
    .ifid_pc_o    (ifid_pc_o),
    .ifid_instr_o (ifid_instr_o),
    .ifid_valid_o (ifid_valid_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive inputs just after a falling edge, let combinational outputs settle.
  task automatic drive(input logic [31:0] pc, input logic ics, input logic [31:0] rd,
                       input logic ids, input logic fl);
    @(negedge clk);
    pc_i = pc; ic_stall_i = ics; ic_rdata_i = rd; id_stall_i = ids; flush_i = fl;
    #1;
  endtask

  task automatic edge_ck();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ifid(input string tag, input logic [31:0] p, input logic [31:0] i,
                          input logic v);
    chk({tag, "_pc"}, ifid_pc_o, p);
    chk({tag, "_instr"}, ifid_instr_o, i);
    chk({tag, "_valid"}, 32'(ifid_valid_o), 32'(v));
  endtask

  task automatic chk_bubble(input string tag);
    chk({tag, "_instr"}, ifid_instr_o, NOPI);
    chk({tag, "_valid"}, 32'(ifid_valid_o), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; pc_i = '0; id_stall_i = 1'b0; flush_i = 1'b0;
    ic_stall_i = 1'b0; ic_rdata_i = 32'hDEAD_BEEF;

    // Reset
    edge_ck();
    chk_ifid("rst", 32'h0, NOPI, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back hits at 0,4,8
    drive(32'h0, 1'b0, 32'hA000_0000, 1'b0, 1'b0);
    chk("hit0_req", 32'(ic_req_o), 32'd1);
    chk("hit0_addr", ic_addr_o, 32'h0);
    chk("hit0_stall", 32'(stall_o), 32'd0);
    edge_ck();
    chk_ifid("hit0", 32'h0, 32'hA000_0000, 1'b1);
    drive(32'h4, 1'b0, 32'hA000_0004, 1'b0, 1'b0);
    chk("hit1_stall", 32'(stall_o), 32'd0);
    edge_ck();
    chk_ifid("hit1", 32'h4, 32'hA000_0004, 1'b1);
    drive(32'h8, 1'b0, 32'hA000_0008, 1'b0, 1'b0);
    chk("hit2_stall", 32'(stall_o), 32'd0);
    edge_ck();
    chk_ifid("hit2", 32'h8, 32'hA000_0008, 1'b1);

    // Miss at 0x40, three busy cycles; pc_i disturbed to prove addr_q is used
    drive(32'h40, 1'b1, 32'h1111_1111, 1'b0, 1'b0);
    chk("miss_c0_stall", 32'(stall_o), 32'd1);
    chk("miss_c0_addr", ic_addr_o, 32'h40);
    edge_ck();
    chk_bubble("miss_b0");
    drive(32'h99, 1'b1, 32'h2222_2222, 1'b0, 1'b0);
    chk("miss_c1_stall", 32'(stall_o), 32'd1);
    chk("miss_c1_addr", ic_addr_o, 32'h40);
    edge_ck();
    chk_bubble("miss_b1");
    drive(32'h99, 1'b1, 32'h3333_3333, 1'b0, 1'b0);
    chk("miss_c2_stall", 32'(stall_o), 32'd1);
    edge_ck();
    chk_bubble("miss_b2");
    drive(32'h99, 1'b0, 32'hB000_0040, 1'b0, 1'b0);
    chk("miss_done_stall", 32'(stall_o), 32'd0);
    chk("miss_done_req", 32'(ic_req_o), 32'd1);
    edge_ck();
    chk_ifid("miss_load", 32'h40, 32'hB000_0040, 1'b1);

    // Hit at 0x10 while decode stalls for two cycles
    drive(32'h10, 1'b0, 32'hC000_0010, 1'b1, 1'b0);
    chk("buf_c0_stall", 32'(stall_o), 32'd1);
    edge_ck();
    chk_ifid("buf_hold0", 32'h40, 32'hB000_0040, 1'b1);
    drive(32'h10, 1'b0, 32'h5555_5555, 1'b1, 1'b0);
    chk("buf_c1_stall", 32'(stall_o), 32'd1);
    chk("buf_c1_req", 32'(ic_req_o), 32'd0);
    edge_ck();
    chk_ifid("buf_hold1", 32'h40, 32'hB000_0040, 1'b1);
    drive(32'h10, 1'b0, 32'h6666_6666, 1'b0, 1'b0);
    chk("buf_rel_stall", 32'(stall_o), 32'd0);
    chk("buf_rel_req", 32'(ic_req_o), 32'd0);
    edge_ck();
    chk_ifid("buf_load", 32'h10, 32'hC000_0010, 1'b1);
    drive(32'h14, 1'b0, 32'hC000_0014, 1'b0, 1'b0);
    chk("buf_next_req", 32'(ic_req_o), 32'd1);
    chk("buf_next_addr", ic_addr_o, 32'h14);
    edge_ck();
    chk_ifid("buf_next", 32'h14, 32'hC000_0014, 1'b1);

    // Flush during a two-cycle miss at 0x20
    drive(32'h20, 1'b1, 32'h7777_7777, 1'b0, 1'b0);
    chk("fw_c0_stall", 32'(stall_o), 32'd1);
    edge_ck();
    chk_bubble("fw_b0");
    drive(32'h20, 1'b1, 32'h7777_7777, 1'b0, 1'b1);
    chk("fw_c1_stall", 32'(stall_o), 32'd1);
    edge_ck();
    chk_bubble("fw_b1");
    drive(32'h20, 1'b0, 32'hBAD0_0020, 1'b0, 1'b1);
    chk("fw_done_stall", 32'(stall_o), 32'd0);
    edge_ck();
    chk_bubble("fw_drop");
    drive(32'h80, 1'b0, 32'hD000_0080, 1'b0, 1'b0);
    chk("fw_tgt_req", 32'(ic_req_o), 32'd1);
    chk("fw_tgt_addr", ic_addr_o, 32'h80);
    chk("fw_tgt_stall", 32'(stall_o), 32'd0);
    edge_ck();
    chk_ifid("fw_tgt", 32'h80, 32'hD000_0080, 1'b1);

    // Flush while buffered under decode stall
    drive(32'h84, 1'b0, 32'hD000_0084, 1'b1, 1'b0);
    chk("fb_c0_stall", 32'(stall_o), 32'd1);
    edge_ck();
    chk_ifid("fb_hold", 32'h80, 32'hD000_0080, 1'b1);
    drive(32'h84, 1'b0, 32'h8888_8888, 1'b1, 1'b1);
    chk("fb_flush_stall", 32'(stall_o), 32'd0);
    edge_ck();
    chk_ifid("fb_flush", 32'h80, NOPI, 1'b0);
    drive(32'hC0, 1'b0, 32'hE000_00C0, 1'b0, 1'b0);
    chk("fb_req", 32'(ic_req_o), 32'd1);
    chk("fb_addr", ic_addr_o, 32'hC0);
    chk("fb_stall", 32'(stall_o), 32'd0);
    edge_ck();
    chk_ifid("fb_tgt", 32'hC0, 32'hE000_00C0, 1'b1);

    // Reset in the middle of a miss
    drive(32'hC4, 1'b1, 32'h9999_9999, 1'b0, 1'b0);
    edge_ck();
    chk("rm_wait_addr", ic_addr_o, 32'hC4);
    @(negedge clk);
    rst_n = 1'b0;
    edge_ck();
    chk_ifid("rm_rst", 32'h0, NOPI, 1'b0);
    drive(32'hC8, 1'b0, 32'hF000_00C8, 1'b0, 1'b0);
    rst_n = 1'b1;
    #1;
    chk("rm_req", 32'(ic_req_o), 32'd1);
    chk("rm_addr", ic_addr_o, 32'hC8);
    chk("rm_stall", 32'(stall_o), 32'd0);
    edge_ck();
    chk_ifid("rm_fresh", 32'hC8, 32'hF000_00C8, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
